pll_phase_ctrl: RTL and testbench
=================================

# pll_phase_ctrl

Run-time phase-shift controller for the GTP_PLL_E3 dynamic phase port. It replaces a compile-time phase setting per output with stepped shifts, issued on request, on up to five PLL outputs. It sits between the video timing/calibration logic and the PLL wrapper. It accepts a channel/direction/step-count request and generates correctly timed PHASE_SEL/PHASE_DIR/PHASE_STEP_N sequences. It then waits for re-lock and reports completion or error.

## Interface
- NUM_CH, 5: number of controllable PLL outputs (1–5); channel n maps to PHASE_SEL = n.
- STEP_W, 8: width of the requested step count.
- PULSE_CYC, 2: cycles phase_step_n is held low per step (≥1).
- GAP_CYC, 4: cycles phase_step_n is held high between steps (≥1).
- LOCK_TO, 1024: cycles allowed in LOCKWAIT before timeout (≥1).
- PHASE_MOD, 40: steps per full period (8 × output divider); position wraps modulo this.
- clk  in  1  controller clock, same domain as requester.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_ch  in  3  target channel.
- req_dir  in  1  1 = advance (late), 0 = retard.
- req_steps  in  STEP_W  number of steps.
- pll_lock  in  1  PLL LOCK, already synchronised to clk.
- phase_sel  out  3  to PLL PHASE_SEL.
- phase_dir  out  1  to PLL PHASE_DIR.
- phase_step_n  out  1  to PLL PHASE_STEP_N, active-low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  valid with done: 0 ok, 1 bad channel, 2 lock lost, 3 lock timeout.
- pos  out  NUM_CH×8  per-channel phase position, channel 0 in bits [7:0].

## Operation
- Reset values: req_ready=1, phase_sel=0, phase_dir=0, phase_step_n=1, busy=0, done=0, err=0, pos=all 0, state IDLE.
- FSM states: IDLE, SETUP, PULSE, GAP, LOCKWAIT, DONE.
- IDLE: on req_valid && req_ready, latch ch/dir/steps.
  - req_ch ≥ NUM_CH goes to DONE with err=1 and issues no pulses.
  - req_steps=0 goes to DONE with err=0.
  - Otherwise goes to SETUP.
- SETUP: 2 cycles with phase_sel/phase_dir driven and phase_step_n=1, then PULSE.
- PULSE: phase_step_n=0 for PULSE_CYC cycles, then GAP. On exit, pos[ch] updates.
  - dir=1: pos+1, wrapping PHASE_MOD-1 → 0.
  - dir=0: pos−1, wrapping 0 → PHASE_MOD-1.
- GAP: phase_step_n=1 for GAP_CYC cycles. Then return to PULSE if steps remain, else go to LOCKWAIT.
- LOCKWAIT: go to DONE err=0 when pll_lock=1. Go to DONE err=3 after LOCK_TO cycles without lock.
- pll_lock low during PULSE or GAP: abort immediately.
  - phase_step_n returns to 1 the next cycle.
  - The remaining steps are discarded and the FSM goes to DONE with err=2.
  - A step already in PULSE still counts in pos.
- DONE: done=1 for one cycle, err held until the next DONE, then IDLE.
- phase_sel and phase_dir hold their values until the next accepted request.
- reset mid-operation: all outputs take their reset values asynchronously, and the in-flight request is lost.

## Timing
- phase_sel and phase_dir are stable ≥2 cycles before the first phase_step_n falling edge and throughout the sequence.
- Latency with pll_lock high, accept at cycle 0:
  - done at cycle 3 + N·(PULSE_CYC+GAP_CYC) + 1.
  - req_ready high the cycle after done.
- A bad-channel or zero-step request gives done at cycle 1.
- All outputs are registered; no combinational path from input to output.

## Configuration
- PLL_PHASE_POS_TRACK_EN defined: the per-channel pos registers and wrap arithmetic are built.
- Undefined: pos is tied to 0, and step sequencing and err are unchanged.

## Structure
- The shared package pll_phase_pkg holds:
  - the FSM state enum;
  - the err code constants ERR_OK/ERR_CH/ERR_LOST/ERR_TO;
  - the SETUP_CYC=2 constant.
- Sub-module pll_phase_pos: one wrapping up/down counter modulo PHASE_MOD, instantiated NUM_CH times under the macro.

## Test plan
- Request ch=0, dir=1, steps=3, lock high, defaults → three low pulses of 2 cycles separated by 4; done at cycle 22; err=0; pos[0]=3.
- Request ch=2, dir=0, steps=1 from pos 0 → pos[2]=39 (wrap); phase_sel=2 during the pulse.
- Request ch=6 → done at cycle 1; err=1; phase_step_n never low.
- Drop pll_lock during the 2nd GAP of a 5-step request → no further pulses; err=2; pos=2.
- Hold pll_lock low after the last step with LOCK_TO=16 → done 16 cycles into LOCKWAIT; err=3.
- Assert rst_n low mid-PULSE → phase_step_n=1, busy=0, req_ready=1 at once; a new request after release runs normally.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift controller.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_LOCKWAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_CH   = 2'd1;
  localparam logic [1:0] ERR_LOST = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  // Cycles PHASE_SEL/PHASE_DIR settle before the first step pulse.
  localparam int SETUP_CYC = 2;

endpackage

// File: rtl/pll_phase_pos.sv
// Wrapping up/down phase position counter, modulo PHASE_MOD.
module pll_phase_pos
  import pll_phase_pkg::*;
#(
  parameter int PHASE_MOD = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  input  logic       dir,
  output logic [7:0] pos
);

  localparam logic [7:0] POS_MAX = 8'(PHASE_MOD - 1);

  // Advance or retard the position by one step, wrapping at the period ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (step_en) begin
      if (dir) pos <= (pos == POS_MAX) ? 8'd0 : pos + 8'd1;
      else     pos <= (pos == 8'd0) ? POS_MAX : pos - 8'd1;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Run-time phase-shift controller for the GTP_PLL_E3 dynamic phase port.
// Optional feature macro: PLL_PHASE_POS_TRACK_EN builds per-channel phase
// position tracking; without it pos reads as all zeros.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a request
// SETUP    | PHASE_SEL/PHASE_DIR driven, settling before first step
// PULSE    | PHASE_STEP_N low for one step
// GAP      | PHASE_STEP_N high between steps
// LOCKWAIT | all steps issued, waiting for PLL re-lock or timeout
// DONE     | one-cycle completion pulse, err updated
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int STEP_W    = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_TO   = 1024,
  parameter int PHASE_MOD = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_ch,
  input  logic                req_dir,
  input  logic [STEP_W-1:0]   req_steps,
  input  logic                pll_lock,
  output logic [2:0]          phase_sel,
  output logic                phase_dir,
  output logic                phase_step_n,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [NUM_CH*8-1:0] pos
);

  localparam int TMR_MAX_A = (LOCK_TO > PULSE_CYC) ? LOCK_TO : PULSE_CYC;
  localparam int TMR_MAX_B = (GAP_CYC > SETUP_CYC) ? GAP_CYC : SETUP_CYC;
  localparam int TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  state_t              state, state_nx;
  logic [TMR_W-1:0]    tmr, tmr_nx;
  logic [STEP_W-1:0]   steps_left, steps_left_nx;
  logic [2:0]          sel_nx;
  logic                dir_nx;
  logic [1:0]          err_nx;
  logic                tmr_zero;

  assign tmr_zero = (tmr == '0);

  // Next-state, timer reload and request latching; outputs are registered
  // from the next state so nothing reaches a port combinationally.
  always_comb begin
    state_nx      = state;
    tmr_nx        = tmr;
    steps_left_nx = steps_left;
    sel_nx        = phase_sel;
    dir_nx        = phase_dir;
    err_nx        = err;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          sel_nx        = req_ch;
          dir_nx        = req_dir;
          steps_left_nx = req_steps;
          if (int'(req_ch) >= NUM_CH) begin
            state_nx = ST_DONE;
            err_nx   = ERR_CH;
          end else if (req_steps == '0) begin
            state_nx = ST_DONE;
            err_nx   = ERR_OK;
          end else begin
            state_nx = ST_SETUP;
            tmr_nx   = TMR_W'(SETUP_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_nx = ST_PULSE;
          tmr_nx   = TMR_W'(PULSE_CYC - 1);
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      ST_PULSE: begin
        // A step that has started counts even if lock drops during it.
        if (!pll_lock) begin
          steps_left_nx = steps_left - STEP_W'(1);
          state_nx      = ST_DONE;
          err_nx        = ERR_LOST;
        end else if (tmr_zero) begin
          steps_left_nx = steps_left - STEP_W'(1);
          state_nx      = ST_GAP;
          tmr_nx        = TMR_W'(GAP_CYC - 1);
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (!pll_lock) begin
          state_nx = ST_DONE;
          err_nx   = ERR_LOST;
        end else if (tmr_zero) begin
          if (steps_left != '0) begin
            state_nx = ST_PULSE;
            tmr_nx   = TMR_W'(PULSE_CYC - 1);
          end else begin
            state_nx = ST_LOCKWAIT;
            tmr_nx   = TMR_W'(LOCK_TO - 1);
          end
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      ST_LOCKWAIT: begin
        if (pll_lock) begin
          state_nx = ST_DONE;
          err_nx   = ERR_OK;
        end else if (tmr_zero) begin
          state_nx = ST_DONE;
          err_nx   = ERR_TO;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      steps_left   <= '0;
      phase_sel    <= '0;
      phase_dir    <= 1'b0;
      phase_step_n <= 1'b1;
      busy         <= 1'b0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      err          <= ERR_OK;
    end else begin
      state        <= state_nx;
      tmr          <= tmr_nx;
      steps_left   <= steps_left_nx;
      phase_sel    <= sel_nx;
      phase_dir    <= dir_nx;
      phase_step_n <= (state_nx != ST_PULSE);
      busy         <= (state_nx != ST_IDLE);
      req_ready    <= (state_nx == ST_IDLE);
      done         <= (state_nx == ST_DONE);
      err          <= err_nx;
    end
  end

`ifdef PLL_PHASE_POS_TRACK_EN
  logic pulse_exit;
  assign pulse_exit = (state == ST_PULSE) && (!pll_lock || tmr_zero);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pos
    pll_phase_pos #(.PHASE_MOD(PHASE_MOD)) u_pos (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_en(pulse_exit && (phase_sel == 3'(i))),
      .dir    (phase_dir),
      .pos    (pos[8*i +: 8])
    );
  end
`else
  assign pos = '0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl (LOCK_TO reduced to 16).
// Position expectations follow PLL_PHASE_POS_TRACK_EN when it is defined.
module tb_pll_phase_ctrl;

  localparam int NCH = 5;
  localparam int P   = 2;
  localparam int G   = 4;
  localparam int LT  = 16;
  localparam int MOD = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_ch;
  logic             req_dir;
  logic [7:0]       req_steps;
  logic             pll_lock;
  logic [2:0]       phase_sel;
  logic             phase_dir;
  logic             phase_step_n;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic [NCH*8-1:0] pos;

  pll_phase_ctrl #(.NUM_CH(NCH), .STEP_W(8), .PULSE_CYC(P), .GAP_CYC(G),
                   .LOCK_TO(LT), .PHASE_MOD(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_dir(req_dir), .req_steps(req_steps),
    .pll_lock(pll_lock), .phase_sel(phase_sel), .phase_dir(phase_dir),
    .phase_step_n(phase_step_n), .busy(busy), .done(done), .err(err),
    .pos(pos)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit chk_en = 0;
  bit m_active = 0;
  int off;
  int m_ch, m_dir, m_done_off, m_err, m_pulses;
  int exp_sel = 0, exp_dir = 0, exp_err = 0;
  int exp_pos[NCH];
  int lows, done_t;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected completion time, error code and issued pulses, derived from
  // the request and the cycle (d) at which lock drops, -1 if never.
  task automatic set_model(input int ch, input int dir, input int n, input int d);
    int seq_end;
    m_ch = ch; m_dir = dir;
    if (ch >= NCH) begin
      m_done_off = 1; m_err = 1; m_pulses = 0;
    end else if (n == 0) begin
      m_done_off = 1; m_err = 0; m_pulses = 0;
    end else begin
      seq_end = 3 + n * (P + G);
      if (d < 0) begin
        m_done_off = seq_end + 1; m_err = 0; m_pulses = n;
      end else if (d >= seq_end) begin
        m_done_off = seq_end + LT; m_err = 3; m_pulses = n;
      end else begin
        m_done_off = d + 1; m_err = 2; m_pulses = (d - 3) / (P + G) + 1;
      end
    end
  endtask

  function automatic bit exp_low(input int t);
    exp_low = 1'b0;
    for (int k = 0; k < m_pulses; k++)
      if (t >= 3 + k * (P + G) && t < 3 + k * (P + G) + P && t < m_done_off)
        exp_low = 1'b1;
  endfunction

  task automatic chk_idle();
    chk("busy_idle", int'(busy), 0);
    chk("ready_idle", int'(req_ready), 1);
    chk("done_idle", int'(done), 0);
    chk("stepn_idle", int'(phase_step_n), 1);
    chk("sel_idle", int'(phase_sel), exp_sel);
    chk("dir_idle", int'(phase_dir), exp_dir);
    chk("err_idle", int'(err), exp_err);
    for (int i = 0; i < NCH; i++) chk("pos_idle", int'(pos[8*i +: 8]), exp_pos[i]);
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!m_active) begin
        chk_idle();
      end else begin
        off++;
        if (off == 0) begin
          chk_idle();
        end else if (off <= m_done_off) begin
          chk("busy", int'(busy), 1);
          chk("ready", int'(req_ready), 0);
          chk("done", int'(done), (off == m_done_off) ? 1 : 0);
          chk("sel", int'(phase_sel), m_ch);
          chk("dir", int'(phase_dir), m_dir);
          chk("stepn", int'(phase_step_n), exp_low(off) ? 0 : 1);
          chk("err", int'(err), (off == m_done_off) ? m_err : exp_err);
          if (!phase_step_n) lows++;
          if (done) done_t = off;
        end else begin
          exp_sel = m_ch; exp_dir = m_dir; exp_err = m_err;
`ifdef PLL_PHASE_POS_TRACK_EN
          if (m_ch < NCH) begin
            if (m_dir != 0) exp_pos[m_ch] = (exp_pos[m_ch] + m_pulses) % MOD;
            else exp_pos[m_ch] = (exp_pos[m_ch] - (m_pulses % MOD) + MOD) % MOD;
          end
`endif
          m_active = 0;
          chk_idle();
        end
      end
    end
  end

  task automatic start_req(input int ch, input int dir, input int n, input int d);
    @(posedge clk); #1;
    set_model(ch, dir, n, d);
    off = -1; lows = 0; done_t = -1; m_active = 1;
    req_valid = 1'b1; req_ch = 3'(ch); req_dir = dir[0]; req_steps = 8'(n);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input int ch, input int dir, input int n, input int d);
    start_req(ch, dir, n, d);
    if (d >= 1) begin
      repeat (d - 1) @(posedge clk);
      #1 pll_lock = 1'b0;
    end
    for (int i = 0; i < 300 && m_active; i++) @(posedge clk);
    if (m_active) begin
      n_vec++; n_err++;
      $display("FAIL completion_timeout: still active, expected done at cycle %0d", m_done_off);
      m_active = 0;
    end
    #1 pll_lock = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) exp_pos[i] = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_ch = '0; req_dir = 1'b0;
    req_steps = '0; pll_lock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stepn", int'(phase_step_n), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sel", int'(phase_sel), 0);
    rst_n = 1'b1;
    @(posedge clk); #1 chk_en = 1;

    run_req(0, 1, 3, -1);
    chk("t1_done_cycle", done_t, 22);
    chk("t1_low_cycles", lows, 6);
    chk("t1_err", int'(err), 0);
`ifdef PLL_PHASE_POS_TRACK_EN
    chk("t1_pos0", int'(pos[7:0]), 3);
`endif

    run_req(2, 0, 1, -1);
    chk("t2_done_cycle", done_t, 10);
`ifdef PLL_PHASE_POS_TRACK_EN
    chk("t2_pos2_wrap", int'(pos[23:16]), 39);
`endif

    run_req(6, 1, 5, -1);
    chk("t3_done_cycle", done_t, 1);
    chk("t3_low_cycles", lows, 0);
    chk("t3_err", int'(err), 1);

    run_req(1, 1, 0, -1);
    chk("t4_done_cycle", done_t, 1);
    chk("t4_err", int'(err), 0);

    run_req(3, 1, 5, 12);
    chk("t5_done_cycle", done_t, 13);
    chk("t5_low_cycles", lows, 4);
    chk("t5_err", int'(err), 2);
`ifdef PLL_PHASE_POS_TRACK_EN
    chk("t5_pos3", int'(pos[31:24]), 2);
`endif

    run_req(1, 0, 1, 9);
    chk("t6_done_cycle", done_t, 25);
    chk("t6_err", int'(err), 3);

    // reset in the middle of the first pulse
    start_req(1, 1, 4, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_stepn", int'(phase_step_n), 0);
    chk_en = 0; m_active = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_stepn", int'(phase_step_n), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(req_ready), 1);
    chk("midrst_pos", (pos == '0) ? 1 : 0, 1);
    exp_sel = 0; exp_dir = 0; exp_err = 0;
    for (int i = 0; i < NCH; i++) exp_pos[i] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk_en = 1;

    run_req(4, 1, 2, -1);
    chk("t8_done_cycle", done_t, 16);
`ifdef PLL_PHASE_POS_TRACK_EN
    chk("t8_pos4", int'(pos[39:32]), 2);
`endif

    run_req(5, 0, 1, -1);
    chk("t9_err", int'(err), 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
